// File: rtl/mp3_pkg.sv
// rtl/mp3_pkg.sv - shared granule constants, sequencer states and side-info record
package mp3_pkg;

    localparam int NUM_LINES = 576;
    localparam int LINE_W    = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [1:0] mode;
        logic [1:0] mode_ext;
        logic [8:0] big_values;
        logic       wsf;
        logic [1:0] block_type;
        logic       mbf;
    } side_info_t;

endpackage

// File: rtl/delay_line.sv
// rtl/delay_line.sv - resettable WIDTH x DEPTH shift register
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/stereo_sequencer.sv
// rtl/stereo_sequencer.sv - issues one granule of sample reads through the joint-stereo datapath and collects results
module stereo_sequencer
    import mp3_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               gr_in,
    input  logic [1:0]         mode_in,
    input  logic [1:0]         mode_ext_in,
    input  logic [8:0]         big_values_in,
    input  logic               window_switching_flag_in,
    input  logic               mixed_block_flag_in,
    input  logic [1:0]         block_type_in,
    input  logic               hold,
    output logic               rd_en,
    output logic [9:0]         rd_addr,
    input  logic signed [31:0] rd_ch1,
    input  logic signed [31:0] rd_ch2,
    output logic signed [31:0] dp_ch1,
    output logic signed [31:0] dp_ch2,
    output logic [9:0]         dp_is_pos,
    output logic               dp_gr,
    output logic               dp_din_v,
    output logic [1:0]         dp_mode,
    output logic [1:0]         dp_mode_ext,
    output logic [8:0]         dp_big_values,
    output logic               dp_wsf,
    output logic [1:0]         dp_block_type,
    output logic               dp_mbf,
    input  logic signed [31:0] dp_ch1_out,
    input  logic signed [31:0] dp_ch2_out,
    input  logic               dp_gr_out,
    input  logic               dp_dout_v,
    output logic               wr_en,
    output logic [9:0]         wr_addr,
    output logic signed [31:0] wr_ch1,
    output logic signed [31:0] wr_ch2,
    output logic               wr_gr,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);
    localparam logic [LINE_W-1:0] ALL_LINES = LINE_W'(NUM_LINES);

    seq_state_t        state, state_nxt;
    logic [LINE_W-1:0] issue_cnt, ret_cnt;
    side_info_t        side_q;
    logic              gr_q;
    logic [LINE_W:0]   al_out;
    logic              al_v;
    logic [LINE_W-1:0] al_addr;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (!hold && issue_cnt == LAST_LINE) state_nxt = DRAIN;
            DRAIN:   if (ret_cnt == ALL_LINES) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            ISSUE: begin
                rd_en = !hold;
                busy  = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign rd_addr = issue_cnt;

    // Read strobe and address travel alongside the BRAM read so data and index meet.
    delay_line #(.WIDTH(LINE_W + 1), .DEPTH(RD_LAT)) u_align (
        .clk  (clk),
        .rst  (rst),
        .din  ({rd_en, rd_addr}),
        .dout (al_out)
    );
    assign {al_v, al_addr} = al_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt <= '0;
            ret_cnt   <= '0;
            side_q    <= '0;
            gr_q      <= 1'b0;
            dp_ch1    <= '0;
            dp_ch2    <= '0;
            dp_is_pos <= '0;
            dp_din_v  <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_ch1    <= '0;
            wr_ch2    <= '0;
            wr_gr     <= 1'b0;
            err       <= 1'b0;
        end else begin
            dp_din_v <= al_v;
            if (al_v) begin
                dp_ch1    <= rd_ch1;
                dp_ch2    <= rd_ch2;
                dp_is_pos <= al_addr;
            end

            if (start && state == IDLE) begin
                side_q    <= '{mode_in, mode_ext_in, big_values_in,
                               window_switching_flag_in, block_type_in, mixed_block_flag_in};
                gr_q      <= gr_in;
                issue_cnt <= '0;
                ret_cnt   <= '0;
            end else if (start) begin
                err <= 1'b1;
            end

            if (rd_en) issue_cnt <= issue_cnt + 1'b1;

            wr_en <= 1'b0;
            if (dp_dout_v) begin
                if (busy && ret_cnt != ALL_LINES) begin
                    wr_en   <= 1'b1;
                    wr_addr <= ret_cnt;
                    wr_ch1  <= dp_ch1_out;
                    wr_ch2  <= dp_ch2_out;
                    wr_gr   <= dp_gr_out;
                    ret_cnt <= ret_cnt + 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign dp_gr         = gr_q;
    assign dp_mode       = side_q.mode;
    assign dp_mode_ext   = side_q.mode_ext;
    assign dp_big_values = side_q.big_values;
    assign dp_wsf        = side_q.wsf;
    assign dp_block_type = side_q.block_type;
    assign dp_mbf        = side_q.mbf;

endmodule

// File: tb/tb_stereo_sequencer.sv
// tb/tb_stereo_sequencer.sv - scoreboard bench for stereo_sequencer with BRAM and echo-datapath models
module tb_stereo_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, gr_in = 1'b0, hold = 1'b0;
    logic [1:0] mode_in = '0, mode_ext_in = '0, block_type_in = '0;
    logic [8:0] big_values_in = '0;
    logic wsf_in = 1'b0, mbf_in = 1'b0;
    logic rd_en, dp_gr, dp_din_v, dp_wsf, dp_mbf, wr_en, wr_gr, busy, done, err;
    logic [9:0] rd_addr, dp_is_pos, wr_addr;
    logic signed [31:0] rd_ch1, rd_ch2, dp_ch1, dp_ch2, wr_ch1, wr_ch2;
    logic signed [31:0] dp_ch1_out, dp_ch2_out;
    logic dp_gr_out, dp_dout_v;
    logic [1:0] dp_mode, dp_mode_ext, dp_block_type;
    logic [8:0] dp_big_values;

    int n_vec = 0, n_bad = 0;
    int base = 0;
    int align_k = 0;
    logic [17:0] exp_side = '0;
    logic [74:0] exp_q [$];
    logic inj_v = 1'b0;

    always #5 clk = ~clk;

    stereo_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .gr_in(gr_in),
        .mode_in(mode_in), .mode_ext_in(mode_ext_in), .big_values_in(big_values_in),
        .window_switching_flag_in(wsf_in), .mixed_block_flag_in(mbf_in),
        .block_type_in(block_type_in), .hold(hold),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_ch1(rd_ch1), .rd_ch2(rd_ch2),
        .dp_ch1(dp_ch1), .dp_ch2(dp_ch2), .dp_is_pos(dp_is_pos), .dp_gr(dp_gr),
        .dp_din_v(dp_din_v), .dp_mode(dp_mode), .dp_mode_ext(dp_mode_ext),
        .dp_big_values(dp_big_values), .dp_wsf(dp_wsf), .dp_block_type(dp_block_type),
        .dp_mbf(dp_mbf), .dp_ch1_out(dp_ch1_out), .dp_ch2_out(dp_ch2_out),
        .dp_gr_out(dp_gr_out), .dp_dout_v(dp_dout_v),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_ch1(wr_ch1), .wr_ch2(wr_ch2), .wr_gr(wr_gr),
        .busy(busy), .done(done), .err(err)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Two-cycle BRAM model: word at addr a holds {base + a, -a}.
    logic [9:0] m_addr;
    always @(posedge clk) begin
        if (rst) begin
            m_addr <= '0;
            rd_ch1 <= '0;
            rd_ch2 <= '0;
        end else begin
            m_addr <= rd_addr;
            rd_ch1 <= 32'(base + int'(m_addr));
            rd_ch2 <= -32'(m_addr);
        end
    end

    // Three-cycle echo datapath model.
    logic [2:0] pv;
    logic [64:0] pd0, pd1, pd2;
    always @(posedge clk) begin
        if (rst) begin
            pv <= '0; pd0 <= '0; pd1 <= '0; pd2 <= '0;
        end else begin
            pv  <= {pv[1:0], dp_din_v};
            pd0 <= {dp_gr, dp_ch1, dp_ch2};
            pd1 <= pd0;
            pd2 <= pd1;
        end
    end
    assign dp_dout_v = pv[2] | inj_v;
    assign {dp_gr_out, dp_ch1_out, dp_ch2_out} = pd2;

    always @(negedge clk) begin
        if (!rst && wr_en) begin
            if (exp_q.size() == 0) check("wr_unexpected", 256'(wr_addr), 256'h0 - 1);
            else check("wr", 256'({wr_addr, wr_ch1, wr_ch2, wr_gr}), 256'(exp_q.pop_front()));
        end
        if (!rst && dp_din_v) begin
            check("align", 256'({dp_is_pos, dp_ch1, dp_ch2}),
                  256'({10'(align_k), 32'(base + align_k), 32'(-align_k)}));
            align_k++;
        end
    end

    task automatic check_all_zero(input string tag);
        check(tag, 256'({rd_en, rd_addr, dp_ch1, dp_ch2, dp_is_pos, dp_gr, dp_din_v, dp_mode,
                         dp_mode_ext, dp_big_values, dp_wsf, dp_block_type, dp_mbf, wr_en,
                         wr_addr, wr_ch1, wr_ch2, wr_gr, busy, done, err}), 256'h0);
    endtask

    task automatic do_start(input logic gr, input int b, input logic [1:0] m, input logic [1:0] me,
                            input logic [8:0] bv, input logic w, input logic [1:0] bt, input logic mb);
        base = b;
        align_k = 0;
        exp_q.delete();
        for (int k = 0; k < 576; k++) exp_q.push_back({10'(k), 32'(b + k), 32'(-k), gr});
        exp_side = {gr, m, me, bv, w, bt, mb};
        @(posedge clk);
        #1;
        gr_in = gr; mode_in = m; mode_ext_in = me; big_values_in = bv;
        wsf_in = w; block_type_in = bt; mbf_in = mb;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc);
        int cyc = 0;
        while (!done && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc % 50 == 0) begin
                check("side", 256'({dp_gr, dp_mode, dp_mode_ext, dp_big_values, dp_wsf,
                                    dp_block_type, dp_mbf}), 256'(exp_side));
                check("busy_run", 256'(busy), 256'(!done));
            end
        end
        check("done_cycles", 256'(cyc), 256'(exp_cyc));
        check("done_busy", 256'({done, busy}), 256'(2'b10));
        check("sb_empty", 256'(exp_q.size()), 256'(0));
        @(posedge clk);
        #1;
        check("after_done", 256'({done, busy}), 256'(2'b00));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        rst = 1'b0;

        do_start(1'b1, 0, 2'b10, 2'b01, 9'd17, 1'b0, 2'b00, 1'b0);
        wait_done(583);

        do_start(1'b0, 1000, 2'b01, 2'b11, 9'd200, 1'b1, 2'b10, 1'b1);
        fork
            wait_done(583);
            begin
                repeat (40) @(posedge clk);
                #1;
                mode_in = 2'b10; mode_ext_in = 2'b00; big_values_in = 9'd5;
                wsf_in = 1'b0; block_type_in = 2'b01; mbf_in = 1'b0; gr_in = 1'b1;
            end
        join

        do_start(1'b1, 7, 2'b11, 2'b10, 9'd300, 1'b0, 2'b11, 1'b0);
        fork
            wait_done(593);
            begin
                repeat (100) @(posedge clk);
                #1 hold = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    check("hold_rd_en", 256'(rd_en), 256'(0));
                    @(posedge clk);
                end
                #1 hold = 1'b0;
            end
        join

        check("err_clean", 256'(err), 256'(0));
        do_start(1'b0, 50, 2'b01, 2'b01, 9'd99, 1'b1, 2'b01, 1'b1);
        fork
            wait_done(583);
            begin
                repeat (50) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        check("err_start_busy", 256'(err), 256'(1));

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("err_after_rst", 256'(err), 256'(0));
        rst = 1'b0;
        inj_v = 1'b1;
        @(posedge clk);
        #1 inj_v = 1'b0;
        check("err_spurious", 256'({err, wr_en}), 256'(2'b10));

        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        do_start(1'b1, 3, 2'b00, 2'b00, 9'd0, 1'b0, 2'b00, 1'b0);
        repeat (300) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all_zero("reset_midrun");
        end
        rst = 1'b0;
        do_start(1'b0, 9, 2'b11, 2'b01, 9'd511, 1'b1, 2'b11, 1'b1);
        wait_done(583);
        check("err_final", 256'(err), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
